dm_frame_sched: RTL and testbench

DM_FRAME_SCHED -- requirements
Module: dm_frame_sched

---
 rtl/dm_pkg.sv | 33 +++
 rtl/dm_coord_counter.sv | 51 +++++
 rtl/dm_frame_sched.sv | 138 +++++++++++++
 tb/tb_dm_frame_sched.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared definitions for the frame scheduler: window codes, FSM encoding
// and the window-code to half-width lookup.
package dm_pkg;

    localparam logic [2:0] WIN3 = 3'b011;
    localparam logic [2:0] WIN5 = 3'b101;
    localparam logic [2:0] WIN7 = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_ADVANCE,
        ST_FINISH
    } dm_state_e;

    // Zero marks an unsupported window code.
    function automatic logic [1:0] half_width(input logic [2:0] win);
        logic [1:0] h;
        case (win)
            WIN3:    h = 2'd1;
            WIN5:    h = 2'd2;
            WIN7:    h = 2'd3;
            default: h = 2'd0;
        endcase
        return h;
    endfunction

    function automatic logic win_valid(input logic [2:0] win);
        return (half_width(win) != 2'd0);
    endfunction

endpackage

// File: rtl/dm_coord_counter.sv
// Raster row/column stepper: columns MAX_DISP-1..IMG_COLS-1-h inside
// rows h..IMG_ROWS-1-h; last flags the final pixel of the frame.
module dm_coord_counter #(
    parameter int IMG_ROWS = 640,
    parameter int IMG_COLS = 480,
    parameter int MAX_DISP = 64,
    parameter int CW       = 12
) (
    input  logic          clkb,
    input  logic          reset,
    input  logic          load,
    input  logic          step,
    input  logic [1:0]    h,
    output logic [CW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    localparam logic [CW-1:0] COL_FIRST = CW'(MAX_DISP - 1);
    localparam logic [CW-1:0] ROWS_M1   = CW'(IMG_ROWS - 1);
    localparam logic [CW-1:0] COLS_M1   = CW'(IMG_COLS - 1);

    logic [CW-1:0] row_q, col_q, h_ext;
    logic          col_end, row_end;

    assign h_ext   = {{(CW-2){1'b0}}, h};
    assign col_end = (col_q == COLS_M1 - h_ext);
    assign row_end = (row_q == ROWS_M1 - h_ext);

    always_ff @(posedge clkb) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else if (load) begin
            row_q <= h_ext;
            col_q <= COL_FIRST;
        end else if (step && !(row_end && col_end)) begin
            if (col_end) begin
                row_q <= row_q + 1'b1;
                col_q <= COL_FIRST;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign row  = row_q;
    assign col  = col_q;
    assign last = row_end && col_end;

endmodule

// File: rtl/dm_frame_sched.sv
// Frame scheduler: issues one pixel job at a time to a block-matching engine
// over the valid raster window and reports frame completion.
//
//   state    | meaning
//   IDLE     | waiting for start with a valid window code
//   ISSUE    | job_valid high, coordinates held until accepted
//   WAIT     | job accepted, waiting for eng_done
//   ADVANCE  | count pixel, step raster or finish
//   FINISH   | frame_done pulse, then back to IDLE
module dm_frame_sched
    import dm_pkg::*;
#(
    parameter int IMG_ROWS = 640,
    parameter int IMG_COLS = 480,
    parameter int MAX_DISP = 64,
    parameter int CW       = 12
) (
    input  logic          clkb,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [2:0]    window,
    output logic          job_valid,
    input  logic          job_ready,
    output logic [CW-1:0] job_row,
    output logic [CW-1:0] job_col,
    output logic [2:0]    job_win,
    input  logic          eng_done,
    output logic          busy,
    output logic          frame_done,
    output logic          cfg_err,
    output logic [18:0]   pix_count
);

    if (MAX_DISP - 1 > IMG_COLS - 4) begin : g_bad_params
        $error("dm_frame_sched: MAX_DISP-1 must not exceed IMG_COLS-4");
    end

    dm_state_e   state_q;
    logic [2:0]  win_q;
    logic [18:0] pix_q;
    logic        job_valid_q, busy_q, frame_done_q, cfg_err_q;
    logic        load, step, last;
    logic [1:0]  h_sel;

    assign load  = (state_q == ST_IDLE) && start && win_valid(window);
    assign step  = (state_q == ST_ADVANCE) && !abort;
    // The counter needs the incoming window's h on load, the latched one after.
    assign h_sel = load ? half_width(window) : half_width(win_q);

    dm_coord_counter #(
        .IMG_ROWS (IMG_ROWS),
        .IMG_COLS (IMG_COLS),
        .MAX_DISP (MAX_DISP),
        .CW       (CW)
    ) u_coord (
        .clkb  (clkb),
        .reset (reset),
        .load  (load),
        .step  (step),
        .h     (h_sel),
        .row   (job_row),
        .col   (job_col),
        .last  (last)
    );

    always_ff @(posedge clkb) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            win_q        <= '0;
            pix_q        <= '0;
            job_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
            if (abort && state_q != ST_IDLE) begin
                state_q     <= ST_IDLE;
                job_valid_q <= 1'b0;
                busy_q      <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (win_valid(window)) begin
                                win_q       <= window;
                                pix_q       <= '0;
                                job_valid_q <= 1'b1;
                                busy_q      <= 1'b1;
                                state_q     <= ST_ISSUE;
                            end else begin
                                cfg_err_q <= 1'b1;
                            end
                        end
                    end
                    ST_ISSUE: begin
                        if (job_ready) begin
                            job_valid_q <= 1'b0;
                            state_q     <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (eng_done) state_q <= ST_ADVANCE;
                    end
                    ST_ADVANCE: begin
                        pix_q <= pix_q + 19'd1;
                        if (last) begin
                            frame_done_q <= 1'b1;
                            state_q      <= ST_FINISH;
                        end else begin
                            job_valid_q <= 1'b1;
                            state_q     <= ST_ISSUE;
                        end
                    end
                    ST_FINISH: begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                    default: begin
                        job_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign job_valid  = job_valid_q;
    assign job_win    = win_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign cfg_err    = cfg_err_q;
    assign pix_count  = pix_q;

endmodule

// File: tb/tb_dm_frame_sched.sv
// Directed bench for dm_frame_sched with a 2-cycle engine model and an
// independent raster sequence model checked on every accepted job.
module tb_dm_frame_sched;

    localparam int IMG_ROWS = 8;
    localparam int IMG_COLS = 70;
    localparam int MAX_DISP = 64;
    localparam int CW       = 12;

    logic          clkb = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    window = 3'b000;
    logic          job_valid;
    logic          job_ready = 1'b1;
    logic [CW-1:0] job_row;
    logic [CW-1:0] job_col;
    logic [2:0]    job_win;
    logic          eng_done = 1'b0;
    logic          busy;
    logic          frame_done;
    logic          cfg_err;
    logic [18:0]   pix_count;

    int n_checks = 0;
    int n_errors = 0;

    int jobs, frames, cfg_errs, valid_seen, eng_cnt;
    int exp_h, exp_row, exp_col, exp_win;
    int abort_job = -1, spur_job = -1;
    bit aborted, spur_done;

    dm_frame_sched #(
        .IMG_ROWS (IMG_ROWS),
        .IMG_COLS (IMG_COLS),
        .MAX_DISP (MAX_DISP),
        .CW       (CW)
    ) dut (
        .clkb       (clkb),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .window     (window),
        .job_valid  (job_valid),
        .job_ready  (job_ready),
        .job_row    (job_row),
        .job_col    (job_col),
        .job_win    (job_win),
        .eng_done   (eng_done),
        .busy       (busy),
        .frame_done (frame_done),
        .cfg_err    (cfg_err),
        .pix_count  (pix_count)
    );

    always #5 clkb = ~clkb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Monitor and engine model at the falling edge; inputs set here are
    // sampled at the following rising edge.
    task automatic tick();
        @(negedge clkb);
        eng_done = 1'b0;
        abort    = 1'b0;
        if (frame_done) frames++;
        if (cfg_err) cfg_errs++;
        if (job_valid) valid_seen++;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                eng_done = 1'b1;
                if (jobs == abort_job && !aborted) begin
                    abort   = 1'b1;
                    aborted = 1'b1;
                end
            end
        end
        if (jobs == spur_job && job_valid && !spur_done) begin
            eng_done  = 1'b1;
            spur_done = 1'b1;
        end
        if (job_valid && job_ready) begin
            chk("job_row", 32'(job_row), 32'(exp_row));
            chk("job_col", 32'(job_col), 32'(exp_col));
            chk("job_win", 32'(job_win), 32'(exp_win));
            jobs++;
            eng_cnt = 2;
            if (exp_col == IMG_COLS - 1 - exp_h) begin
                exp_col = MAX_DISP - 1;
                exp_row++;
            end else begin
                exp_col++;
            end
        end
        @(posedge clkb);
        #1;
    endtask

    task automatic start_frame(input logic [2:0] w, input int h);
        window     = w;
        exp_h      = h;
        exp_row    = h;
        exp_col    = MAX_DISP - 1;
        exp_win    = 32'(w);
        jobs       = 0;
        frames     = 0;
        cfg_errs   = 0;
        valid_seen = 0;
        eng_cnt    = 0;
        aborted    = 1'b0;
        spur_done  = 1'b0;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_frame(input int budget);
        int n = 0;
        while (frames == 0 && n < budget) begin
            tick();
            n++;
        end
        chk("frame_done_seen", 32'(frames), 32'd1);
    endtask

    initial begin
        repeat (3) tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_valid", 32'(job_valid), 32'd0);
        chk("rst_pix", 32'(pix_count), 32'd0);
        chk("rst_row", 32'(job_row), 32'd0);
        chk("rst_col", 32'(job_col), 32'd0);
        chk("rst_win", 32'(job_win), 32'd0);
        chk("rst_fdone", 32'(frame_done), 32'd0);
        chk("rst_cfgerr", 32'(cfg_err), 32'd0);
        reset = 1'b0;
        tick();

        // window 3x3: rows 1..6, cols 63..68
        start_frame(3'b011, 1);
        chk("busy_after_start", 32'(busy), 32'd1);
        wait_frame(1000);
        chk("w3_jobs", 32'(jobs), 32'd36);
        chk("w3_pix", 32'(pix_count), 32'd36);
        tick();
        chk("w3_busy_end", 32'(busy), 32'd0);
        chk("w3_one_pulse", 32'(frames), 32'd1);
        repeat (3) tick();
        chk("w3_pix_hold", 32'(pix_count), 32'd36);

        // window 7x7: rows 3..4, cols 63..66
        start_frame(3'b111, 3);
        wait_frame(1000);
        chk("w7_jobs", 32'(jobs), 32'd8);
        chk("w7_pix", 32'(pix_count), 32'd8);
        tick();

        // invalid window code
        start_frame(3'b100, 0);
        repeat (3) tick();
        chk("bad_cfgerr", 32'(cfg_errs), 32'd1);
        chk("bad_busy", 32'(busy), 32'd0);
        chk("bad_valid", 32'(valid_seen), 32'd0);
        chk("bad_pix_hold", 32'(pix_count), 32'd8);

        // back-pressure on the first job
        job_ready = 1'b0;
        start_frame(3'b011, 1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(job_valid), 32'd1);
            chk("stall_row", 32'(job_row), 32'd1);
            chk("stall_col", 32'(job_col), 32'd63);
            chk("stall_win", 32'(job_win), 32'd3);
            tick();
        end
        job_ready = 1'b1;
        wait_frame(1000);
        chk("stall_jobs", 32'(jobs), 32'd36);
        tick();

        // abort together with eng_done in WAIT of job 10
        abort_job = 10;
        start_frame(3'b011, 1);
        for (int n = 0; n < 1000 && !aborted; n++) tick();
        chk("abort_seen", 32'(aborted), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_valid", 32'(job_valid), 32'd0);
        chk("abort_pix", 32'(pix_count), 32'd9);
        abort_job = -1;
        repeat (5) tick();
        chk("abort_no_fdone", 32'(frames), 32'd0);
        chk("abort_jobs", 32'(jobs), 32'd10);
        chk("abort_pix_hold", 32'(pix_count), 32'd9);
        start_frame(3'b011, 1);
        wait_frame(1000);
        chk("post_abort_jobs", 32'(jobs), 32'd36);
        chk("post_abort_pix", 32'(pix_count), 32'd36);
        tick();

        // spurious eng_done in ISSUE, and start with a new window while busy
        spur_job = 5;
        start_frame(3'b011, 1);
        repeat (20) tick();
        window = 3'b111;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        chk("busy_start_win", 32'(job_win), 32'd3);
        wait_frame(1000);
        chk("spur_done_fired", 32'(spur_done), 32'd1);
        chk("spur_jobs", 32'(jobs), 32'd36);
        chk("spur_pix", 32'(pix_count), 32'd36);
        spur_job = -1;
        tick();

        // reset mid-frame wins over start
        start_frame(3'b101, 2);
        repeat (15) tick();
        reset = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_valid", 32'(job_valid), 32'd0);
        chk("mid_rst_pix", 32'(pix_count), 32'd0);
        chk("mid_rst_row", 32'(job_row), 32'd0);
        chk("mid_rst_win", 32'(job_win), 32'd0);
        reset = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
